// File: rtl/pattern_gen.sv
// Programmable stimulus source: replays a pattern memory, counts up from a seed,
// or repeatedly right-shifts a seed, presenting one word per beat on a valid/ready bus.
module pattern_gen #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  parameter  int SHIFT = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [15:0]      count,
  input  logic             start,
  input  logic             stop,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] number,
  output logic             last,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  state_t           state;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] seed_q;
  logic [15:0]      remain;
  logic             free_q;
  logic             stop_pend;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_val;
  logic             accept;
  logic             start_ok;
  logic             final_beat;

  assign accept     = out_valid & out_ready;
  assign start_ok   = (state == IDLE) && start && (mode != 2'b11);
  // The presented beat is final if it is beat N of a counted run or a stop is (or was) seen.
  assign final_beat = last | stop_pend | stop;
  assign shifted    = number >> SHIFT;

  always_comb begin
    next_val = number;
    case (mode_q)
      2'b00:   next_val = mem[addr];
      2'b01:   next_val = number + WIDTH'(1);
      default: next_val = (shifted == '0) ? seed_q : shifted;
    endcase
  end

  // Memory has no reset so patterns survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE && !start_ok)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 2'b00;
      seed_q    <= '0;
      remain    <= '0;
      free_q    <= 1'b0;
      stop_pend <= 1'b0;
      addr      <= '0;
      out_valid <= 1'b0;
      number    <= '0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state     <= RUN;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            mode_q    <= mode;
            seed_q    <= seed;
            remain    <= count;
            free_q    <= (count == 16'd0);
            stop_pend <= 1'b0;
            last      <= (count == 16'd1);
            addr      <= AW'(1);
            number    <= (mode == 2'b00) ? mem[0] : seed;
          end
        end
        RUN: begin
          if (accept) begin
            if (final_beat) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              last      <= 1'b0;
              stop_pend <= 1'b0;
              done      <= 1'b1;
            end else begin
              number <= next_val;
              addr   <= addr + AW'(1);
              if (!free_q) remain <= remain - 16'd1;
              last   <= !free_q && (remain == 16'd2);
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed + randomized bench for pattern_gen, checked against a per-run beat-list model.
module tb_pattern_gen;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int SHIFT = 2;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       mode;
  logic [WIDTH-1:0] seed;
  logic [15:0]      count;
  logic             start, stop, wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] number;
  logic             last, busy, done;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [WIDTH-1:0] mem_m [DEPTH];

  pattern_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .seed(seed), .count(count),
    .start(start), .stop(stop), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_ready(out_ready), .out_valid(out_valid), .number(number), .last(last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Value of beat i for a run, straight from the mode rules.
  function automatic logic [WIDTH-1:0] beat_val(input logic [1:0] m, input logic [WIDTH-1:0] s,
                                                 input int i);
    logic [WIDTH-1:0] v;
    case (m)
      2'b00: return mem_m[i % DEPTH];
      2'b01: begin v = s + WIDTH'(i); return v; end
      default: begin
        v = s;
        for (int k = 0; k < i; k++) begin
          v = v / (1 << SHIFT);
          if (v == 0) v = s;
        end
        return v;
      end
    endcase
  endfunction

  task automatic mem_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    mem_m[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // wr_mode: 0 none, 1 write addr0 mid-run, 2 write addr0 alongside start (both must drop).
  task automatic do_run(input string tag, input logic [1:0] m, input logic [WIDTH-1:0] s,
                        input int cnt, input int stop_at, input bit use_pat,
                        input logic [63:0] rpat, input int wr_mode);
    int idx, cyc;
    bit fin, stop_sent, final_b, rdy;
    @(negedge clk);
    mode = m; seed = s; count = 16'(cnt); start = 1'b1; out_ready = 1'b0;
    if (wr_mode == 2) begin wr_en = 1'b1; wr_addr = '0; wr_data = 8'h66; end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    idx = 0; cyc = 0; fin = 0; stop_sent = 0;
    while (!fin && cyc < 400) begin
      check({tag, " valid"}, out_valid, 1);
      check({tag, " busy"}, busy, 1);
      check({tag, " number"}, number, beat_val(m, s, idx));
      check({tag, " last"}, last, (cnt != 0 && idx == cnt - 1));
      rdy = use_pat ? rpat[cyc] : ($urandom_range(99) < 70);
      if (stop_at == idx && !stop_sent) begin stop = 1'b1; stop_sent = 1; end
      else stop = 1'b0;
      if (wr_mode == 1 && cyc == 1) begin wr_en = 1'b1; wr_addr = '0; wr_data = 8'h55; end
      else wr_en = 1'b0;
      out_ready = rdy;
      final_b = (cnt != 0 && idx == cnt - 1) || stop_sent;
      if (rdy) begin
        idx++;
        if (final_b) fin = 1;
      end
      cyc++;
      @(negedge clk);
    end
    stop = 1'b0; out_ready = 1'b0; wr_en = 1'b0;
    check({tag, " finished"}, fin, 1);
    check({tag, " end valid"}, out_valid, 0);
    check({tag, " end busy"}, busy, 0);
    check({tag, " end last"}, last, 0);
    check({tag, " done pulse"}, done, 1);
    @(negedge clk);
    check({tag, " done low"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; mode = '0; seed = '0; count = '0; start = 1'b0; stop = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst valid", out_valid, 0);
    check("rst number", number, 0);
    check("rst last", last, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    rst_n = 1'b1;

    mem_write(0, 8'hA0); mem_write(1, 8'hA1); mem_write(2, 8'hA2); mem_write(3, 8'hA3);
    for (int a = 4; a < DEPTH; a++) mem_write(AW'(a), 8'($urandom));

    do_run("replay6", 2'b00, 8'h00, 6, -1, 1, '1, 0);
    do_run("cnt_wrap", 2'b01, 8'hFE, 3, -1, 1, '1, 0);
    do_run("shift_free", 2'b10, 8'h80, 0, 5, 1, '1, 0);
    do_run("shift_stop", 2'b10, 8'h80, 0, 2, 1, 64'h13, 0);
    do_run("shift_zero", 2'b10, 8'h00, 4, -1, 1, '1, 0);
    do_run("cnt_bp", 2'b01, 8'h10, 4, -1, 1, 64'h69, 0);
    do_run("cnt_stop_end", 2'b01, 8'h40, 3, 2, 1, '1, 0);
    do_run("replay_wr_mid", 2'b00, 8'h00, 0, 17, 1, '1, 1);
    do_run("replay_wr_start", 2'b00, 8'h00, 2, -1, 1, '1, 2);

    // Reserved mode must not start a run.
    @(negedge clk); mode = 2'b11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("mode11 busy", busy, 0);
    check("mode11 valid", out_valid, 0);

    // Reset after three accepted beats of a counted run of 8.
    @(negedge clk); mode = 2'b01; seed = 8'h30; count = 16'd8; start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      check("rstmid number", number, beat_val(2'b01, 8'h30, b));
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid valid", out_valid, 0);
    check("rstmid number0", number, 0);
    check("rstmid busy", busy, 0);
    check("rstmid last", last, 0);
    check("rstmid done", done, 0);
    rst_n = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check("rstmid no done", done, 0);
    do_run("replay_after_rst", 2'b00, 8'h00, 16, -1, 1, '1, 0);

    for (int r = 0; r < 8; r++) begin
      logic [1:0] m;
      logic [WIDTH-1:0] s;
      int cnt, sa;
      m  = 2'($urandom_range(2));
      s  = 8'($urandom);
      if ($urandom_range(3) == 0) begin
        cnt = 0; sa = $urandom_range(25);
      end else begin
        cnt = $urandom_range(20, 1);
        sa = ($urandom_range(3) == 0) ? $urandom_range(cnt - 1) : -1;
      end
      do_run("random", m, s, cnt, sa, 0, '0, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pattern_gen.md
# pattern_gen

Parametrised stimulus/pattern generator that drives a `number` bus with a valid/ready handshake. It replaces fixed per-test stimulus modules with one programmable source. The source can replay a small pattern memory, count up from a seed, or repeatedly shift a seed right. It sits at the front of a test or datapath chain and feeds any block that consumes one word per accepted beat.

## Interface
Parameters:
- `WIDTH`, 8, data width of `number`, seed and memory words
- `DEPTH`, 16, pattern memory words (power of two, ≥2); `AW = $clog2(DEPTH)`
- `SHIFT`, 2, right-shift amount per beat in shift mode (1..WIDTH-1)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `mode`  in  2  00 replay, 01 count, 10 shift, 11 reserved; sampled on `start`
- `seed`  in  WIDTH  start value for count and shift modes; sampled on `start`
- `count`  in  16  beats to emit; 0 = free-run until `stop`; sampled on `start`
- `start`  in  1  begin a run (honoured only in IDLE)
- `stop`  in  1  end a free or counted run early
- `wr_en`  in  1  pattern memory write strobe
- `wr_addr`  in  AW  write address
- `wr_data`  in  WIDTH  write data
- `out_ready`  in  1  consumer accepts the current beat
- `out_valid`  out  1  `number` holds a valid beat
- `number`  out  WIDTH  current beat value
- `last`  out  1  current beat is the final beat of a counted run
- `busy`  out  1  FSM not in IDLE
- `done`  out  1  one-cycle pulse after the final beat is accepted

## Operation
- FSM states: IDLE, RUN.
- IDLE → RUN on `start` while `mode != 11`.
  - `start` with `mode == 11` is ignored.
  - `start` while in RUN is ignored.
- RUN holds `out_valid` = 1 for its whole duration.
- A beat is accepted when `out_valid & out_ready`. The next value loads on the same edge.
- Beat values by mode:
  - Replay: `mem[0], mem[1], …, mem[DEPTH-1], mem[0], …`. The address wraps modulo DEPTH.
  - Count: `seed, seed+1, …`, modulo 2^WIDTH. `FF` is followed by `00` at WIDTH=8.
  - Shift: `v, v>>SHIFT, …` using a logical shift. When the next value would be 0, reload `seed` instead. A seed of 0 emits 0 every beat.
- Counted run (`count` = N > 0):
  - Exactly N beats are emitted.
  - `last` = 1 together with beat N.
  - Accepting beat N returns the FSM to IDLE.
- Run ending via `stop`:
  - `stop` in RUN latches a stop-pending flag.
  - The beat currently presented becomes the final beat and still waits for `out_ready`. Its data is not changed.
  - `last` is not asserted for a stopped run.
- `stop` and an accept in the same cycle: the accepted beat is the final beat, and the FSM enters IDLE on the next edge.
- `stop` on the same edge that a counted run would end anyway: same result, and `done` pulses once.
- `stop` in IDLE has no effect.
- Memory writes:
  - Honoured only in IDLE and not in a cycle with an honoured `start`, since `start` has priority. Dropped writes are silent.
  - The memory is not cleared by reset.

## Timing
- All outputs are registered.
- Reset values: `out_valid` = 0, `number` = 0, `last` = 0, `busy` = 0, `done` = 0. The FSM resets to IDLE and internal counters/address reset to 0.
- `start` sampled at edge t:
  - `busy` = 1 and `out_valid` = 1 from t+1.
  - The first beat (mem[0] or `seed`) is on `number` at t+1.
  - `last` = 1 at t+1 if `count` = 1.
- Throughput is one beat per cycle while `out_ready` = 1. Latency from accept to the next value is one edge.
- Backpressure: while `out_ready` = 0, `number`, `last` and `out_valid` hold stable.
- Final accept at edge t:
  - `out_valid`, `busy` and `last` fall at t+1.
  - `done` = 1 for cycle t+1 only.
  - A new `start` is honoured at t+1 at the earliest.
- Reset mid-run (`rst_n` = 0 sampled at edge t): all outputs take their reset values at t+1 and no `done` pulse is produced. Memory contents are preserved.

## Test plan
- Write mem[0..3] = A0,A1,A2,A3. Start replay with `count` = 6 and `out_ready` = 1. Required beats: A0,A1,A2,A3,mem[4],mem[5]; `last` on beat 6; `done` one cycle after.
- Count mode, `seed` = FE, `count` = 3 (WIDTH 8). Required beats: FE, FF, 00; `last` with 00.
- Shift mode, `seed` = 80, `SHIFT` = 2, free-run. Required beats: 80,20,08,02,80,20. Assert `stop` while 08 is presented with `out_ready` = 0, then raise `out_ready` 2 cycles later. Required: 08 held stable until accepted, then IDLE, `last` = 0, `done` pulses.
- Count mode, `seed` = 10, `count` = 4, `out_ready` toggled 1,0,0,1,0,1,1. Required: exactly 10,11,12,13 delivered; no value changes while not ready.
- Replay free-run with `wr_en` to addr 0 mid-run. Required: the write is dropped. Later, with `start` and `wr_en` in the same IDLE cycle, the write is also dropped and the run starts.
- Counted run of 8: deassert `rst_n` after beat 3. Required: all outputs 0 on the next edge and no `done`. Then start a replay and confirm the earlier memory contents are intact.
